// File: rtl/multi_lane_encoder_pkg.sv
// Shared types and constants for the multi-lane USB4 TX symbol encoder.
// Defines the speed modes, the d_sel codes, the sync headers and the per-mode symbol length.
package usb4_enc_pkg;

  typedef enum logic [1:0] {
    GEN2 = 2'd0,
    GEN4 = 2'd1,
    GEN3 = 2'd2
  } gen_speed_e;

  localparam logic [3:0] D_SEL_CTRL = 4'd8;
  localparam logic [3:0] D_SEL_IDLE = 4'd9;

  localparam logic [1:0] HDR66_DATA  = 2'b01;
  localparam logic [1:0] HDR66_CTRL  = 2'b10;
  localparam logic [3:0] HDR132_DATA = 4'b1010;
  localparam logic [3:0] HDR132_CTRL = 4'b0101;

  localparam int unsigned CNT_W = $clog2(17);

  // Reserved speed code 3 falls back to pass-through.
  function automatic gen_speed_e decode_speed(input logic [1:0] speed);
    case (speed)
      2'd1:    return GEN4;
      2'd2:    return GEN3;
      default: return GEN2;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sym_len(input gen_speed_e mode);
    case (mode)
      GEN3:    return CNT_W'(8);
      GEN4:    return CNT_W'(16);
      default: return CNT_W'(1);
    endcase
  endfunction

endpackage

// File: rtl/multi_lane_encoder_if.sv
// Byte-stream input and symbol-stream output of the lane encoder, bundled as one port.
// The encoder sits on the slave side; the upstream mux / serializer pair is the master.
interface multi_lane_encoder_if #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned SYM_W     = 132
);

  logic [3:0]                 d_sel;
  logic [8*NUM_LANES-1:0]     lane_tx;
  logic                       in_valid;
  logic                       in_ready;
  logic [SYM_W*NUM_LANES-1:0] lane_tx_enc;
  logic                       enc_valid;
  logic                       enc_ready;
  logic                       new_sym;
  logic                       sym_ctrl;
  logic                       abort_pulse;

  modport master (
    output d_sel, lane_tx, in_valid, enc_ready,
    input  in_ready, lane_tx_enc, enc_valid, new_sym, sym_ctrl, abort_pulse
  );

  modport slave (
    input  d_sel, lane_tx, in_valid, enc_ready,
    output in_ready, lane_tx_enc, enc_valid, new_sym, sym_ctrl, abort_pulse
  );

endinterface

// File: rtl/multi_lane_encoder_enc_lane_packer.sv
// One lane's byte accumulator and header insertion.
// The formatted symbol already includes the byte written this cycle, so a completing beat can load directly.
module enc_lane_packer
  import usb4_enc_pkg::*;
#(
  parameter int unsigned SYM_W = 132
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr,
  input  logic [3:0]       idx,
  input  logic [7:0]       data,
  input  gen_speed_e       mode,
  input  logic             ctrl,
  output logic [SYM_W-1:0] sym
);

  logic [127:0] acc, acc_nxt;
  logic [131:0] full;

  always_comb begin
    acc_nxt = acc;
    if (wr) begin
      if (idx == '0) acc_nxt = {120'b0, data};
      else           acc_nxt[8*idx +: 8] = data;
    end
    full = '0;
    case (mode)
      GEN3:    full[65:0] = {acc_nxt[63:0], ctrl ? HDR66_CTRL : HDR66_DATA};
      GEN4:    full       = {acc_nxt, ctrl ? HDR132_CTRL : HDR132_DATA};
      default: full[7:0]  = acc_nxt[7:0];
    endcase
    sym = SYM_W'(full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else          acc <= acc_nxt;
  end

endmodule

// File: rtl/multi_lane_encoder.sv
// Multi-lane 64b/66b, 128b/132b or pass-through encoder with valid/ready on both sides.
// Byte counter, speed tracking, abort detection and the FILL/HOLD output stage are shared by all lanes.
module multi_lane_encoder
  import usb4_enc_pkg::*;
#(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned SYM_W     = 132
) (
  input  logic               enc_clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         gen_speed,
  multi_lane_encoder_if.slave bus
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]                 state, state_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt, idx;
  gen_speed_e                 mode_in, sym_mode, sym_mode_nxt;
  logic                       ctrl_q, ctrl_nxt;
  logic                       beat, abort, complete, out_free, load;
  logic                       in_ready_q, enc_valid_q, new_sym_q, sym_ctrl_q, abort_q;
  logic [SYM_W*NUM_LANES-1:0] sym_all, enc_sym;

  always_comb begin
    mode_in  = decode_speed(gen_speed);
    beat     = bus.in_valid & in_ready_q & (bus.d_sel != D_SEL_IDLE);
    // A speed change or idle beat only matters while a partial symbol exists.
    abort    = (cnt != '0) &
               ((bus.in_valid & (bus.d_sel == D_SEL_IDLE)) | (mode_in != sym_mode));
    idx      = abort ? '0 : cnt;
    sym_mode_nxt = sym_mode;
    ctrl_nxt     = ctrl_q;
    if (beat && idx == '0) begin
      sym_mode_nxt = mode_in;
      ctrl_nxt     = (bus.d_sel == D_SEL_CTRL);
    end
    complete = beat && (idx == sym_len(sym_mode_nxt) - CNT_W'(1));
    cnt_nxt  = cnt;
    if (beat)       cnt_nxt = complete ? '0 : idx + CNT_W'(1);
    else if (abort) cnt_nxt = '0;
    out_free  = !enc_valid_q || bus.enc_ready;
    load      = (state == FILL) ? (complete && out_free) : bus.enc_ready;
    state_nxt = state;
    if (state == FILL && complete && !out_free) state_nxt = HOLD;
    else if (state == HOLD && bus.enc_ready)    state_nxt = FILL;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    enc_lane_packer #(.SYM_W(SYM_W)) u_packer (
      .clk   (enc_clk),
      .rst_n (rst),
      .clr   (!enable),
      .wr    (beat),
      .idx   (idx[3:0]),
      .data  (bus.lane_tx[8*l +: 8]),
      .mode  (sym_mode_nxt),
      .ctrl  (ctrl_nxt),
      .sym   (sym_all[SYM_W*l +: SYM_W])
    );
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;  cnt <= '0;  sym_mode <= GEN2;  ctrl_q <= 1'b0;
      in_ready_q <= 1'b0;  enc_valid_q <= 1'b0;  new_sym_q <= 1'b0;
      sym_ctrl_q <= 1'b0;  abort_q <= 1'b0;  enc_sym <= '0;
    end else if (!enable) begin
      state <= FILL;  cnt <= '0;  sym_mode <= GEN2;  ctrl_q <= 1'b0;
      in_ready_q <= 1'b0;  enc_valid_q <= 1'b0;  new_sym_q <= 1'b0;
      sym_ctrl_q <= 1'b0;  abort_q <= 1'b0;  enc_sym <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sym_mode    <= sym_mode_nxt;
      ctrl_q      <= ctrl_nxt;
      in_ready_q  <= (state_nxt == FILL);
      enc_valid_q <= load | (enc_valid_q & !bus.enc_ready);
      new_sym_q   <= load;
      abort_q     <= abort;
      if (load) begin
        enc_sym    <= sym_all;
        sym_ctrl_q <= ctrl_nxt;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.enc_valid   = enc_valid_q;
  assign bus.new_sym     = new_sym_q;
  assign bus.sym_ctrl    = sym_ctrl_q;
  assign bus.abort_pulse = abort_q;
  assign bus.lane_tx_enc = enc_sym;

endmodule

// File: tb/tb_multi_lane_encoder.sv
// Self-checking bench for multi_lane_encoder: directed scenarios plus randomized traffic
// scored against a queue-based reference packer that assembles symbols with plain arithmetic.
module tb_multi_lane_encoder;

  localparam int L  = 2;
  localparam int W  = 132;
  localparam int CW = 300;
  typedef logic [CW-1:0] cv_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] gen_speed = 2'd0;

  multi_lane_encoder_if #(.NUM_LANES(L), .SYM_W(W)) bus ();

  multi_lane_encoder #(.NUM_LANES(L), .SYM_W(W)) dut (
    .enc_clk   (clk),
    .rst       (rst),
    .enable    (enable),
    .gen_speed (gen_speed),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input cv_t got, input cv_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [L*W-1:0] exp_q[$];
  logic           exp_ctrl_q[$];
  logic [7:0]     part[L][16];
  int             part_len, part_mode, n_pushed, n_new;
  bit             part_ctrl, exp_abort;

  function automatic int len_of(input logic [1:0] gs);
    return (gs == 2'd1) ? 16 : (gs == 2'd2) ? 8 : 1;
  endfunction

  function automatic logic [W-1:0] encode(input int lane);
    logic [W-1:0] d = '0;
    for (int k = part_mode - 1; k >= 0; k--) d = (d << 8) | W'(part[lane][k]);
    if (part_mode == 8)  return (d << 2) | W'(part_ctrl ? 2 : 1);
    if (part_mode == 16) return (d << 4) | W'(part_ctrl ? 5 : 10);
    return d;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    exp_ctrl_q.delete();
    part_len  = 0;
    n_pushed  = 0;
    n_new     = 0;
    exp_abort = 0;
  endtask

  // Drive one cycle (called just after a negedge), score it, and return after the next negedge.
  task automatic step(input bit v, input logic [3:0] ds, input logic [1:0] gs,
                      input logic [8*L-1:0] data, input bit rdy, output bit acc);
    logic [L*W-1:0] sym, stall_sym;
    bit stall, ab;
    int len;
    bus.in_valid = v;  bus.d_sel = ds;  gen_speed = gs;
    bus.lane_tx = data;  bus.enc_ready = rdy;
    acc = v && ds != 4'd9 && bus.in_ready;
    ab = 0;
    if (enable) begin
      if (bus.enc_valid && rdy) begin
        check_eq("queue_has_sym", cv_t'(exp_q.size() != 0), cv_t'(1));
        if (exp_q.size() != 0) begin
          check_eq("sym_data", cv_t'(bus.lane_tx_enc), cv_t'(exp_q.pop_front()));
          check_eq("sym_ctrl", cv_t'(bus.sym_ctrl), cv_t'(exp_ctrl_q.pop_front()));
        end
      end
      len = len_of(gs);
      if (part_len != 0 && len != part_mode) begin ab = 1; part_len = 0; end
      if (v && ds == 4'd9 && part_len != 0)  begin ab = 1; part_len = 0; end
      if (acc) begin
        if (part_len == 0) begin part_mode = len; part_ctrl = (ds == 4'd8); end
        for (int l = 0; l < L; l++) part[l][part_len] = data[8*l +: 8];
        part_len++;
        if (part_len == part_mode) begin
          for (int l = 0; l < L; l++) sym[l*W +: W] = encode(l);
          exp_q.push_back(sym);
          exp_ctrl_q.push_back(part_ctrl);
          n_pushed++;
          part_len = 0;
        end
      end
    end
    stall = enable && bus.enc_valid && !rdy;
    stall_sym = bus.lane_tx_enc;
    @(negedge clk);
    if (!enable) begin
      clear_model();
    end else begin
      check_eq("abort_pulse", cv_t'(bus.abort_pulse), cv_t'(ab));
      if (stall) check_eq("hold_stable", cv_t'(bus.lane_tx_enc), cv_t'(stall_sym));
      if (bus.new_sym) n_new++;
    end
  endtask

  function automatic cv_t outs();
    return cv_t'({bus.in_ready, bus.enc_valid, bus.new_sym, bus.sym_ctrl,
                  bus.abort_pulse, bus.lane_tx_enc});
  endfunction

  task automatic do_reset();
    #2 rst = 1'b0;
    #1 check_eq("reset_outputs_zero", outs(), '0);
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 60 && (exp_q.size() != 0 || bus.enc_valid); i++)
      step(0, 4'd0, gen_speed, '0, 1, a);
    check_eq("drain_queue_empty", cv_t'(exp_q.size()), '0);
    check_eq("drain_valid_low", cv_t'(bus.enc_valid), '0);
    check_eq("new_sym_count", cv_t'(n_new), cv_t'(n_pushed));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int got;
    logic [7:0] b;
    bus.in_valid = 0;  bus.d_sel = 0;  bus.lane_tx = '0;  bus.enc_ready = 0;
    clear_model();
    @(negedge clk);
    check_eq("reset_state", outs(), '0);
    @(negedge clk);
    rst = 1'b1;
    step(0, 4'd0, 2'd2, '0, 1, a);
    check_eq("in_ready_after_reset", cv_t'(bus.in_ready), cv_t'(1));

    // Gen3 single symbol, latency and new_sym pulse
    for (int i = 0; i < 8; i++) begin
      b = 8'(i);
      step(1, 4'd0, 2'd2, {b + 8'h10, b}, 1, a);
      if (i == 6) check_eq("gen3_valid_before_last", cv_t'(bus.enc_valid), '0);
    end
    check_eq("gen3_valid", cv_t'(bus.enc_valid), cv_t'(1));
    check_eq("gen3_new_sym", cv_t'(bus.new_sym), cv_t'(1));
    check_eq("gen3_lane0", cv_t'(bus.lane_tx_enc[0 +: W]), cv_t'({64'h0706050403020100, 2'b01}));
    check_eq("gen3_lane1", cv_t'(bus.lane_tx_enc[W +: W]), cv_t'({64'h1716151413121110, 2'b01}));
    step(0, 4'd0, 2'd2, '0, 1, a);
    check_eq("gen3_new_sym_pulse", cv_t'(bus.new_sym), '0);
    check_eq("gen3_valid_drop", cv_t'(bus.enc_valid), '0);

    // Gen4 control symbol; d_sel only counts on byte 0
    for (int i = 0; i < 16; i++) begin
      b = 8'(i);
      step(1, (i == 0) ? 4'd8 : 4'd0, 2'd1, {b + 8'h50, b + 8'hA0}, 1, a);
    end
    check_eq("gen4_lane0", cv_t'(bus.lane_tx_enc[0 +: W]),
             cv_t'({128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 4'b0101}));
    check_eq("gen4_ctrl", cv_t'(bus.sym_ctrl), cv_t'(1));
    drain();

    // Gen3 back-to-back with a stalled serializer
    got = 0;
    for (int c = 0; c < 100 && got < 24; c++) begin
      b = 8'(got);
      step(1, 4'd0, 2'd2, {b + 8'h40, b}, c >= 20, a);
      if (a) got++;
      if (c == 19) begin
        check_eq("stall_in_ready", cv_t'(bus.in_ready), '0);
        check_eq("stall_accepted", cv_t'(got), cv_t'(16));
      end
    end
    check_eq("stall_all_accepted", cv_t'(got), cv_t'(24));
    drain();

    // Idle abort after 5 bytes, then a clean symbol
    for (int i = 0; i < 5; i++) step(1, 4'd0, 2'd2, {8'hEE, 8'(i)}, 1, a);
    step(1, 4'd9, 2'd2, '0, 1, a);
    check_eq("idle_abort_pulse", cv_t'(bus.abort_pulse), cv_t'(1));
    for (int i = 0; i < 8; i++) begin
      b = 8'(i);
      step(1, 4'd0, 2'd2, {b + 8'hD0, b + 8'hC0}, 1, a);
    end
    check_eq("post_abort_lane0", cv_t'(bus.lane_tx_enc[0 +: W]), cv_t'({64'hC7C6C5C4C3C2C1C0, 2'b01}));
    step(1, 4'd9, 2'd2, '0, 1, a);
    check_eq("idle_no_partial", cv_t'(bus.abort_pulse), '0);
    drain();

    // Gen2 pass-through
    step(1, 4'd0, 2'd0, {8'h11, 8'h5A}, 1, a);
    check_eq("gen2_first", cv_t'(bus.lane_tx_enc[0 +: W]), cv_t'(8'h5A));
    step(1, 4'd0, 2'd0, {8'h22, 8'h3C}, 1, a);
    check_eq("gen2_second", cv_t'(bus.lane_tx_enc[0 +: W]), cv_t'(8'h3C));
    check_eq("gen2_valid", cv_t'(bus.enc_valid), cv_t'(1));
    drain();

    // Reset mid-symbol, mid-HOLD, and sync clear via enable
    for (int i = 0; i < 3; i++) step(1, 4'd0, 2'd2, {8'h99, 8'h77}, 1, a);
    do_reset();
    step(0, 4'd0, 2'd2, '0, 1, a);
    for (int i = 0; i < 8; i++) step(1, 4'd0, 2'd2, {8'(i) + 8'h30, 8'(i) + 8'h20}, 1, a);
    drain();
    for (int i = 0; i < 20; i++) step(1, 4'd0, 2'd2, {8'(i), 8'(i) + 8'h60}, 0, a);
    check_eq("hold_in_ready", cv_t'(bus.in_ready), '0);
    do_reset();
    step(0, 4'd0, 2'd2, '0, 1, a);
    for (int i = 0; i < 4; i++) step(1, 4'd0, 2'd2, {8'h12, 8'h34}, 1, a);
    enable = 1'b0;
    step(0, 4'd0, 2'd2, '0, 0, a);
    check_eq("enable_clear", outs(), '0);
    enable = 1'b1;
    step(0, 4'd0, 2'd2, '0, 1, a);
    for (int i = 0; i < 8; i++) step(1, 4'd0, 2'd2, {8'(i) + 8'h90, 8'(i) + 8'h80}, 1, a);
    drain();

    // Randomized traffic against the reference packer
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] gs;
      logic [3:0] ds;
      int r;
      gs = gen_speed;
      if ($urandom_range(0, 39) == 0) gs = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 99);
      ds = (r < 5) ? 4'd9 : (r < 15) ? 4'd8 : 4'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, ds, gs, 16'($urandom), $urandom_range(0, 9) < 7, a);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
